// File: rtl/me_pkg.sv
// Shared types and default sizing for the motion-estimation sequencer.
package me_pkg;

  localparam int ME_ADDR_SW  = 12;
  localparam int ME_ADDR_TB  = 8;
  localparam int ME_PIPE_LAT = 4;

  localparam int TB_N = 1 << ME_ADDR_TB;
  localparam int SW_N = 1 << ME_ADDR_SW;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_TB,
    ST_LOAD_SW,
    ST_SEARCH,
    ST_DRAIN,
    ST_DONE
  } me_state_e;

endpackage

// File: rtl/me_beat_cnt.sv
// Terminal-count beat counter: wraps to zero when it advances past its terminal value.
module me_beat_cnt #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == term_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = last_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/me_seq_ctrl.sv
// Top sequencer: TB load, SW load, SW search stream, PE drain, done pulse.
// Optional ME_SEQ_STALL_EN adds pe_stall to freeze SEARCH/DRAIN.
module me_seq_ctrl
  import me_pkg::*;
#(
  parameter int ADDR_SW  = ME_ADDR_SW,
  parameter int ADDR_TB  = ME_ADDR_TB,
  parameter int PIPE_LAT = ME_PIPE_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic pix_valid,
`ifdef ME_SEQ_STALL_EN
  input  logic pe_stall,
`endif
  output logic pix_ready,
  output logic clr,
  output logic en_sw,
  output logic en_tb,
  output logic tb_we,
  output logic sw_we,
  output logic pe_en,
  output logic busy,
  output logic done
);

  localparam logic [ADDR_SW-1:0] TB_TERM = ADDR_SW'((1 << ADDR_TB) - 1);
  localparam logic [ADDR_SW-1:0] SW_TERM = '1;
  localparam logic [ADDR_SW-1:0] DR_TERM = ADDR_SW'(PIPE_LAT - 1);

  me_state_e          state_q;
  logic               stall, hs;
  logic               cnt_clr, cnt_en, cnt_last;
  logic [ADDR_SW-1:0] cnt_term;

`ifdef ME_SEQ_STALL_EN
  assign stall = pe_stall;
`else
  assign stall = 1'b0;
`endif

  assign hs = pix_valid & pix_ready;

  always_comb begin
    pix_ready = 1'b0;
    clr       = 1'b0;
    en_sw     = 1'b0;
    en_tb     = 1'b0;
    tb_we     = 1'b0;
    sw_we     = 1'b0;
    pe_en     = 1'b0;
    done      = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    cnt_term  = SW_TERM;
    busy      = (state_q != ST_IDLE);
    case (state_q)
      // clr is gated by rst_n so outputs drop the moment reset asserts
      ST_IDLE: begin
        clr     = start & rst_n;
        cnt_clr = start;
      end
      ST_LOAD_TB: begin
        pix_ready = 1'b1;
        en_tb     = hs;
        tb_we     = hs;
        cnt_en    = hs;
        cnt_term  = TB_TERM;
      end
      // final SW beat clears the address generator; clr beats en_sw there
      ST_LOAD_SW: begin
        pix_ready = 1'b1;
        en_sw     = hs;
        sw_we     = hs;
        clr       = hs & cnt_last;
        cnt_en    = hs;
      end
      ST_SEARCH: begin
        en_sw  = ~stall;
        pe_en  = ~stall;
        cnt_en = ~stall;
      end
      ST_DRAIN: begin
        cnt_en   = ~stall;
        cnt_term = DR_TERM;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else begin
      case (state_q)
        ST_IDLE:    if (start)               state_q <= ST_LOAD_TB;
        ST_LOAD_TB: if (hs && cnt_last)      state_q <= ST_LOAD_SW;
        ST_LOAD_SW: if (hs && cnt_last)      state_q <= ST_SEARCH;
        ST_SEARCH:  if (!stall && cnt_last)  state_q <= ST_DRAIN;
        ST_DRAIN:   if (!stall && cnt_last)  state_q <= ST_DONE;
        ST_DONE:                             state_q <= ST_IDLE;
        default:                             state_q <= ST_IDLE;
      endcase
    end
  end

  me_beat_cnt #(.W(ADDR_SW)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .term_i (cnt_term),
    .last_o (cnt_last)
  );

endmodule
